fila_bytes: RTL and testbench
=============================

# fila_bytes

Byte queue that sits directly downstream of the serial deserializer. It accepts each assembled byte through the deserializer's data_ready/ack handshake and stores it in a DEPTH-entry circular buffer. It returns bytes in FIFO order to a consumer on dequeue requests. It provides backpressure by withholding the ack while full.

## Interface
- DEPTH, 8, number of byte entries; power of two, at least 2
- WIDTH, 8, bits per entry
- clk_100KHz  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- data_in  in  WIDTH  byte from the deserializer's data_out
- data_ready_in  in  1  byte available (the deserializer's data_ready)
- ack_out  out  1  acknowledge to the deserializer's ack_in
- deq_in  in  1  consumer dequeue request, sampled every cycle
- data_out  out  WIDTH  most recently dequeued byte
- valid_out  out  1  one-cycle pulse: data_out updated this cycle
- len_out  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- full_out  out  1  len_out == DEPTH
- empty_out  out  1  len_out == 0
- err_out  out  1  sticky underflow flag (present only with FILA_ERR_EN)

## Operation
**Capture FSM**, two states:
- IDLE
  - If data_ready_in=1 and full_out=0: write data_in to mem[wr_ptr], increment wr_ptr, set ack_out<=1, go to WAIT_DROP.
  - If data_ready_in=1 and full_out=1: no write, ack_out stays 0, remain in IDLE. The producer blocks and keeps its byte.
- WAIT_DROP
  - Hold ack_out=1 until data_ready_in is sampled 0.
  - Then set ack_out<=0 and go to IDLE.
  - Exactly one write per handshake, however long data_ready_in stays high.

**Dequeue path**, independent of the FSM:
- deq_in=1 and empty_out=0: data_out<=mem[rd_ptr], increment rd_ptr, valid_out<=1 for one cycle.
- deq_in=1 and empty_out=1: ignored. data_out holds, valid_out=0. Sets err_out when FILA_ERR_EN is defined.
- Holding deq_in=1 pops one byte per cycle until the queue is empty.

**Pointers and count**
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- len is tracked in a separate counter.
- Write and pop in the same cycle: both occur and len is unchanged.
- full_out and empty_out are evaluated on the pre-edge len. A same-cycle pop never frees a slot for a same-cycle write, and a same-cycle write never feeds a same-cycle pop.
- Stored contents are never cleared by a pop.

## Timing
- Reset values: ack_out=0, data_out=0, valid_out=0, len_out=0, full_out=0, empty_out=1, err_out=0, FSM=IDLE, pointers=0.
- Reset mid-handshake drops ack_out immediately and discards all contents.
- Write latency: data_ready_in sampled high at edge N with space available → entry written and ack_out=1 after edge N. len_out increments after edge N.
- ack_out falls on the first edge at which data_ready_in is sampled 0.
- Pop latency: deq_in sampled at edge N → data_out and valid_out valid after edge N. len_out decrements after edge N.
- Full stall: once a slot frees (len drops after edge M), a pending data_ready_in is accepted at edge M+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- FILA_ERR_EN defined:
  - err_out port exists.
  - It is set to 1 on the first edge where deq_in=1 while empty_out=1.
  - It stays 1 until reset.
- FILA_ERR_EN undefined: err_out port and its logic are absent. Underflow requests are silently ignored.

## Test plan
- **Reset:** assert reset mid-handshake with ack_out=1 → ack_out=0, len_out=0, empty_out=1, data_out=0 on the same cycle.
- **Single transfer:** data_ready_in=1 with data_in=8'hA5, held 3 cycles → exactly one write, len_out=1, ack_out high until data_ready_in drops. Then deq_in pulse → data_out=8'hA5, valid_out pulse, len_out=0.
- **Fill:** write 8 bytes 8'h01..8'h08 → full_out=1. A 9th byte 8'h09 gets no ack. One deq returns 8'h01, then 8'h09 is acked on the next cycle and len_out=8.
- **Wrap-around:** 20 interleaved writes and pops with wr_ptr/rd_ptr crossing index 7→0 → output order is exactly the input order, with no loss or duplication.
- **Simultaneous events:** write and pop at len_out=4 on the same edge → len_out stays 4. Pop at len_out=0 with a same-cycle write → no valid_out, len_out=1.
- **Underflow** (FILA_ERR_EN defined): deq_in on an empty queue → valid_out=0, data_out unchanged, err_out=1 and held until reset.

Source files
------------

// File: rtl/fila_bytes_if.sv
// -----------------------------------------------------------------------------
// fila_bytes_if
// Bundles the producer handshake, the consumer dequeue port and the status
// outputs of fila_bytes.
//   slave  : the queue itself (reads data_in/data_ready_in/deq_in, drives the rest)
//   master : the surrounding logic (deserializer + consumer)
// Parameters DEPTH/WIDTH must match the fila_bytes instance.
// err_out exists only when FILA_ERR_EN is defined.
// -----------------------------------------------------------------------------
interface fila_bytes_if #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] data_in;
    logic             data_ready_in;
    logic             ack_out;
    logic             deq_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic [LW-1:0]    len_out;
    logic             full_out;
    logic             empty_out;

`ifdef FILA_ERR_EN
    logic             err_out;

    modport slave (
        input  data_in, data_ready_in, deq_in,
        output ack_out, data_out, valid_out, len_out, full_out, empty_out, err_out
    );
    modport master (
        output data_in, data_ready_in, deq_in,
        input  ack_out, data_out, valid_out, len_out, full_out, empty_out, err_out
    );
`else
    modport slave (
        input  data_in, data_ready_in, deq_in,
        output ack_out, data_out, valid_out, len_out, full_out, empty_out
    );
    modport master (
        output data_in, data_ready_in, deq_in,
        input  ack_out, data_out, valid_out, len_out, full_out, empty_out
    );
`endif
endinterface

// File: rtl/fila_bytes.sv
// -----------------------------------------------------------------------------
// fila_bytes
// Byte queue downstream of the serial deserializer. Bytes are captured through
// the data_ready/ack handshake into a DEPTH-entry circular buffer and returned
// in FIFO order on dequeue requests. Backpressure: ack is withheld while full.
//
// Ports:
//   clk_100KHz : system clock, rising edge
//   reset      : asynchronous, active-high
//   bus        : fila_bytes_if.slave
//                data_in/data_ready_in/ack_out  producer handshake
//                deq_in/data_out/valid_out      consumer dequeue port
//                len_out/full_out/empty_out     occupancy status
//                err_out                        sticky underflow (FILA_ERR_EN)
//
// Optional feature macro: FILA_ERR_EN (adds the sticky underflow flag).
// -----------------------------------------------------------------------------
module fila_bytes #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic         clk_100KHz,
    input  logic         reset,
    fila_bytes_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic {
        IDLE,
        WAIT_DROP
    } state_t;

    state_t           state_reg, state_next;
    logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [LW-1:0]    len_reg, len_next;
    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;
    logic             wr_en, rd_en;
    logic             full, empty;

    logic [WIDTH-1:0] mem [DEPTH];

    // Status comes from the pre-edge count, so a same-cycle pop never frees a
    // slot for a same-cycle write and vice versa.
    assign full  = (len_reg == LW'(DEPTH));
    assign empty = (len_reg == '0);
    assign rd_en = bus.deq_in && !empty;

    // Capture FSM: one write per handshake, ack held until data_ready drops.
    always_comb begin
        state_next = state_reg;
        wr_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.data_ready_in && !full) begin
                    wr_en      = 1'b1;
                    state_next = WAIT_DROP;
                end
            end
            WAIT_DROP: begin
                if (!bus.data_ready_in) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        len_next = len_reg;
        case ({wr_en, rd_en})
            2'b10:   len_next = len_reg + 1'b1;
            2'b01:   len_next = len_reg - 1'b1;
            default: len_next = len_reg;
        endcase
    end

    always_ff @(posedge clk_100KHz or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            len_reg    <= '0;
            data_reg   <= '0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            valid_reg <= rd_en;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                data_reg   <= mem[rd_ptr_reg];
            end
        end
    end

    // Storage has no reset: emptiness is tracked by len/pointers only, and a
    // pop never clears an entry.
    always_ff @(posedge clk_100KHz) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= bus.data_in;
        end
    end

`ifdef FILA_ERR_EN
    logic err_reg;

    always_ff @(posedge clk_100KHz or posedge reset) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if (bus.deq_in && empty) begin
            err_reg <= 1'b1;
        end
    end

    assign bus.err_out = err_reg;
`endif

    // ack is exactly "handshake already captured", i.e. the WAIT_DROP state bit.
    assign bus.ack_out   = (state_reg == WAIT_DROP);
    assign bus.data_out  = data_reg;
    assign bus.valid_out = valid_reg;
    assign bus.len_out   = len_reg;
    assign bus.full_out  = full;
    assign bus.empty_out = empty;

endmodule

// File: tb/tb_fila_bytes.sv
// -----------------------------------------------------------------------------
// tb_fila_bytes
// Randomized and directed stimulus for fila_bytes, checked against a queue-based
// reference model. Inputs change 1 time unit after the rising edge, outputs
// are sampled at the same point.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fila_bytes;
    localparam int DEPTH = 8;
    localparam int WIDTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk_100KHz;
    logic reset;

    fila_bytes_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    fila_bytes #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk_100KHz (clk_100KHz),
        .reset      (reset),
        .bus        (bus)
    );

    initial clk_100KHz = 1'b0;
    always #5 clk_100KHz = ~clk_100KHz;

    int total = 0;
    int bad   = 0;

    // Reference model: contents as a queue, plus "this handshake already
    // accepted" flag and the last popped byte.
    logic [WIDTH-1:0] q[$];
    bit               m_taken;
    logic [WIDTH-1:0] m_data;
    bit               m_valid;
    bit               m_err;

    task automatic model_reset();
        q.delete();
        m_taken = 0;
        m_data  = '0;
        m_valid = 0;
        m_err   = 0;
    endtask

    // Apply one cycle of inputs, advance the model with pre-edge rules, clock.
    task automatic step(input bit dr, input logic [WIDTH-1:0] din, input bit deq);
        bit full_m, empty_m, wr, rd;
        bus.data_ready_in = dr;
        bus.data_in       = din;
        bus.deq_in        = deq;
        full_m  = (q.size() == DEPTH);
        empty_m = (q.size() == 0);
        wr = dr && !m_taken && !full_m;
        rd = deq && !empty_m;
        m_valid = rd;
        if (rd) m_data = q.pop_front();
        if (wr) q.push_back(din);
        if (wr) m_taken = 1;
        else if (!dr) m_taken = 0;
        if (deq && empty_m) m_err = 1;
        @(posedge clk_100KHz);
        #1;
        if (bus.valid_out === 1'b1)
            $display("pop  data=%02h len=%0d", bus.data_out, bus.len_out);
        if (wr)
            $display("push data=%02h", din);
    endtask

    task automatic test_reset();
        total++; if (bus.ack_out !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b want=0", bus.ack_out); end
        total++; if (bus.len_out !== '0) begin bad++; $display("FAIL rst_len got=%0d want=0", bus.len_out); end
        total++; if (bus.empty_out !== 1'b1 || bus.full_out !== 1'b0) begin bad++; $display("FAIL rst_flags got e=%b f=%b want e=1 f=0", bus.empty_out, bus.full_out); end
        total++; if (bus.data_out !== '0 || bus.valid_out !== 1'b0) begin bad++; $display("FAIL rst_data got=%02h v=%b want=00 v=0", bus.data_out, bus.valid_out); end
        step(1, 8'h3C, 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 1);
        total++; if (bus.data_out !== 8'h3C) begin bad++; $display("FAIL rst_pre_pop got=%02h want=3c", bus.data_out); end
        step(1, 8'h7E, 0);
        total++; if (bus.ack_out !== 1'b1) begin bad++; $display("FAIL rst_pre_ack got=%b want=1", bus.ack_out); end
        // Asynchronous reset mid-handshake: effect must be visible before any edge.
        reset = 1'b1;
        #1;
        total++; if (bus.ack_out !== 1'b0) begin bad++; $display("FAIL rst_async_ack got=%b want=0", bus.ack_out); end
        total++; if (bus.len_out !== '0 || bus.empty_out !== 1'b1) begin bad++; $display("FAIL rst_async_len got=%0d e=%b want=0 e=1", bus.len_out, bus.empty_out); end
        total++; if (bus.data_out !== '0) begin bad++; $display("FAIL rst_async_data got=%02h want=00", bus.data_out); end
        bus.data_ready_in = 1'b0;
        @(posedge clk_100KHz);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        for (int i = 0; i < 3; i++) begin
            step(1, 8'hA5, 0);
            total++; if (bus.ack_out !== 1'b1 || bus.len_out !== LW'(1)) begin bad++; $display("FAIL single_hold%0d got ack=%b len=%0d want ack=1 len=1", i, bus.ack_out, bus.len_out); end
        end
        step(0, 8'h00, 0);
        total++; if (bus.ack_out !== 1'b0 || bus.len_out !== LW'(1)) begin bad++; $display("FAIL single_drop got ack=%b len=%0d want ack=0 len=1", bus.ack_out, bus.len_out); end
        step(0, 8'h00, 1);
        total++; if (bus.data_out !== 8'hA5 || bus.valid_out !== 1'b1 || bus.len_out !== '0) begin bad++; $display("FAIL single_pop got d=%02h v=%b len=%0d want d=a5 v=1 len=0", bus.data_out, bus.valid_out, bus.len_out); end
        step(0, 8'h00, 0);
        total++; if (bus.valid_out !== 1'b0) begin bad++; $display("FAIL single_pulse got v=%b want v=0", bus.valid_out); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1, WIDTH'(i), 0);
            step(0, 8'h00, 0);
        end
        total++; if (bus.full_out !== 1'b1 || bus.len_out !== LW'(DEPTH)) begin bad++; $display("FAIL fill_full got f=%b len=%0d want f=1 len=%0d", bus.full_out, bus.len_out, DEPTH); end
        step(1, 8'h09, 0);
        step(1, 8'h09, 0);
        total++; if (bus.ack_out !== 1'b0 || bus.len_out !== LW'(DEPTH)) begin bad++; $display("FAIL fill_stall got ack=%b len=%0d want ack=0 len=%0d", bus.ack_out, bus.len_out, DEPTH); end
        step(1, 8'h09, 1);
        total++; if (bus.data_out !== 8'h01 || bus.valid_out !== 1'b1 || bus.ack_out !== 1'b0) begin bad++; $display("FAIL fill_pop got d=%02h v=%b ack=%b want d=01 v=1 ack=0", bus.data_out, bus.valid_out, bus.ack_out); end
        step(1, 8'h09, 0);
        total++; if (bus.ack_out !== 1'b1 || bus.len_out !== LW'(DEPTH)) begin bad++; $display("FAIL fill_resume got ack=%b len=%0d want ack=1 len=%0d", bus.ack_out, bus.len_out, DEPTH); end
        step(0, 8'h00, 0);
        for (int i = 2; i <= 9; i++) begin
            step(0, 8'h00, 1);
            total++; if (bus.data_out !== WIDTH'(i) || bus.valid_out !== 1'b1) begin bad++; $display("FAIL fill_drain got d=%02h v=%b want d=%02h v=1", bus.data_out, bus.valid_out, WIDTH'(i)); end
        end
        total++; if (bus.empty_out !== 1'b1) begin bad++; $display("FAIL fill_empty got e=%b want e=1", bus.empty_out); end
    endtask

    // Random interleaving; with DEPTH=8 the pointers cross 7->0 many times.
    task automatic test_wrap_random();
        for (int c = 0; c < 400; c++) begin
            bit dr, deq;
            dr  = ($urandom % 4) != 0;
            deq = (c < 200) ? (($urandom % 4) == 0) : (($urandom % 2) == 0);
            step(dr, WIDTH'($urandom), deq);
            total++;
            if (bus.ack_out !== m_taken || bus.valid_out !== m_valid || bus.data_out !== m_data ||
                bus.len_out !== LW'(q.size()) || bus.full_out !== (q.size() == DEPTH) ||
                bus.empty_out !== (q.size() == 0)) begin
                bad++;
                $display("FAIL wrap_c%0d got ack=%b v=%b d=%02h len=%0d f=%b e=%b want ack=%b v=%b d=%02h len=%0d",
                         c, bus.ack_out, bus.valid_out, bus.data_out, bus.len_out, bus.full_out, bus.empty_out,
                         m_taken, m_valid, m_data, q.size());
            end
        end
        step(0, 8'h00, 0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(0, 8'h00, 1);
            total++; if (bus.data_out !== m_data || bus.valid_out !== m_valid) begin bad++; $display("FAIL wrap_drain got d=%02h v=%b want d=%02h v=%b", bus.data_out, bus.valid_out, m_data, m_valid); end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 4; i++) begin
            step(1, 8'h40 + WIDTH'(i), 0);
            step(0, 8'h00, 0);
        end
        total++; if (bus.len_out !== LW'(4)) begin bad++; $display("FAIL sim_setup got len=%0d want 4", bus.len_out); end
        step(1, 8'h5A, 1);
        total++; if (bus.len_out !== LW'(4) || bus.valid_out !== 1'b1 || bus.data_out !== 8'h40 || bus.ack_out !== 1'b1) begin bad++; $display("FAIL sim_wr_rd got len=%0d v=%b d=%02h ack=%b want len=4 v=1 d=40 ack=1", bus.len_out, bus.valid_out, bus.data_out, bus.ack_out); end
        step(0, 8'h00, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 1);
        total++; if (bus.data_out !== 8'h5A || bus.empty_out !== 1'b1) begin bad++; $display("FAIL sim_drain got d=%02h e=%b want d=5a e=1", bus.data_out, bus.empty_out); end
        step(1, 8'hC3, 1);
        total++; if (bus.valid_out !== 1'b0 || bus.len_out !== LW'(1) || bus.data_out !== 8'h5A) begin bad++; $display("FAIL sim_empty got v=%b len=%0d d=%02h want v=0 len=1 d=5a", bus.valid_out, bus.len_out, bus.data_out); end
        step(0, 8'h00, 1);
        total++; if (bus.data_out !== 8'hC3 || bus.valid_out !== 1'b1) begin bad++; $display("FAIL sim_after got d=%02h v=%b want d=c3 v=1", bus.data_out, bus.valid_out); end
    endtask

    task automatic test_underflow();
        logic [WIDTH-1:0] held;
        held = bus.data_out;
        step(0, 8'h00, 1);
        total++; if (bus.valid_out !== 1'b0 || bus.data_out !== held || bus.len_out !== '0) begin bad++; $display("FAIL uf_pop got v=%b d=%02h len=%0d want v=0 d=%02h len=0", bus.valid_out, bus.data_out, bus.len_out, held); end
`ifdef FILA_ERR_EN
        total++; if (bus.err_out !== m_err) begin bad++; $display("FAIL uf_err got=%b want=%b", bus.err_out, m_err); end
        step(1, 8'h11, 0);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0);
        total++; if (bus.err_out !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%b want=1", bus.err_out); end
        reset = 1'b1;
        #1;
        total++; if (bus.err_out !== 1'b0) begin bad++; $display("FAIL uf_clear got=%b want=0", bus.err_out); end
        @(posedge clk_100KHz);
        #1;
        reset = 1'b0;
        model_reset();
`endif
    endtask

    initial begin
        reset             = 1'b1;
        bus.data_in       = '0;
        bus.data_ready_in = 1'b0;
        bus.deq_in        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_100KHz);
        #1;
        reset = 1'b0;

        test_reset();
        test_single();
        test_fill();
        test_wrap_random();
        test_simultaneous();
        test_underflow();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
